ctrl_stage: RTL

Registered, handshaked decode stage for the 9-bit ISA, sitting between instruction fetch and the datapath. It decodes one instruction per transfer into jump/branch strobes, register addresses, immediate and a 5-bit OP. Memory ops are held off the output for a configurable latency, and a synchronous flush supports taken branches and jumps. Undefined opcodes are flagged.

---
 rtl/ctrl_stage.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ctrl_stage.sv
// Registered decode stage for the 9-bit ISA with valid/ready handshake,
// memory-op latency hold-off, synchronous flush and illegal-opcode flagging.
module ctrl_stage #(
  parameter int         MEM_LAT = 2,
  parameter logic [2:0] DEF_REG = 3'b001
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] Instruction,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       Jump,
  output logic       BranchEn,
  output logic [2:0] RegReadAddr,
  output logic [2:0] RegWriteAddr,
  output logic [4:0] Imm,
  output logic [4:0] OP,
  output logic       MemBusy,
  output logic       Illegal,
  output logic       IllegalSeen
);

  localparam int CW       = $clog2(MEM_LAT + 1);
  localparam bit MEM_HOLD = (MEM_LAT > 1);

  typedef enum logic [1:0] {EMPTY, FULL, MEMWAIT} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            jump_reg, branch_reg, illegal_reg, illegal_seen_reg;
  logic [2:0]      rra_reg, rwa_reg;
  logic [4:0]      imm_reg, op_reg;

  logic            d_jump, d_branch, d_illegal, d_mem;
  logic [2:0]      d_rra, d_rwa;
  logic [4:0]      d_imm, d_op;
  logic            accept;

  always_comb begin
    d_op      = '0;
    d_imm     = '0;
    d_rra     = DEF_REG;
    d_rwa     = DEF_REG;
    d_jump    = 1'b0;
    d_branch  = 1'b0;
    d_illegal = 1'b0;
    d_mem     = 1'b0;
    unique case (Instruction[1:0])
      2'b00: begin
        d_rra = Instruction[8:6];
        if (Instruction[5:2] <= 4'd8) begin
          d_op = {1'b0, Instruction[5:2]};
        end else begin
          d_op      = 5'd31;
          d_illegal = 1'b1;
        end
        if (Instruction[5:2] == 4'd1) d_rwa = Instruction[8:6];
        d_mem = (Instruction[5:2] == 4'd7) || (Instruction[5:2] == 4'd8);
      end
      2'b01: begin
        d_branch = 1'b1;
        d_rra    = Instruction[6:4];
        d_imm    = {2'b00, Instruction[8:6]};
        d_op     = {3'b100, Instruction[3:2]};
      end
      2'b10: begin
        d_imm  = Instruction[8:4];
        d_op   = {3'b101, Instruction[3:2]};
        d_jump = &Instruction[3:2];
      end
      default: begin
        d_rra = Instruction[5:3];
        d_rwa = Instruction[5:3];
        d_imm = {2'b00, Instruction[8:6]};
        d_op  = {4'b1100, Instruction[2]};
      end
    endcase
  end

  assign in_ready = ~flush & ((state_reg == EMPTY) | ((state_reg == FULL) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (flush) begin
      state_next = EMPTY;
      cnt_next   = '0;
    end else begin
      unique case (state_reg)
        EMPTY, FULL: begin
          if (accept) begin
            // Memory ops park in MEMWAIT unless the latency is a single cycle.
            if (d_mem && MEM_HOLD) begin
              state_next = MEMWAIT;
              cnt_next   = CW'(MEM_LAT - 1);
            end else begin
              state_next = FULL;
              cnt_next   = '0;
            end
          end else if (state_reg == FULL && out_ready) begin
            state_next = EMPTY;
          end
        end
        default: begin
          if (cnt_reg <= CW'(1)) begin
            state_next = FULL;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg        <= EMPTY;
      cnt_reg          <= '0;
      jump_reg         <= 1'b0;
      branch_reg       <= 1'b0;
      illegal_reg      <= 1'b0;
      illegal_seen_reg <= 1'b0;
      rra_reg          <= DEF_REG;
      rwa_reg          <= DEF_REG;
      imm_reg          <= '0;
      op_reg           <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        jump_reg    <= d_jump;
        branch_reg  <= d_branch;
        illegal_reg <= d_illegal;
        rra_reg     <= d_rra;
        rwa_reg     <= d_rwa;
        imm_reg     <= d_imm;
        op_reg      <= d_op;
        if (d_illegal) illegal_seen_reg <= 1'b1;
      end
    end
  end

  assign out_valid    = (state_reg == FULL);
  assign MemBusy      = (state_reg == MEMWAIT);
  assign Jump         = jump_reg & out_valid;
  assign BranchEn     = branch_reg & out_valid;
  assign Illegal      = illegal_reg & out_valid;
  assign IllegalSeen  = illegal_seen_reg;
  assign RegReadAddr  = rra_reg;
  assign RegWriteAddr = rwa_reg;
  assign Imm          = imm_reg;
  assign OP           = op_reg;

endmodule
